// File: rtl/uart_tx_fifo_ctrl_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM encoding and sizing helpers.
package uart_tx_fifo_ctrl_pkg;

    // Same bit period as the 16-clock-per-bit receiver.
    localparam int unsigned DefaultClksPerBit = 16;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } tx_state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous byte FIFO with show-ahead read data and a level output.
module uart_byte_fifo #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push,
    input  logic                        pop,
    input  logic [7:0]                  din,
    output logic [7:0]                  dout,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(FIFO_DEPTH):0] level
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PtrOne = (AW+1)'(1);

    // Extra MSB on each pointer separates full from empty when the indices match.
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic [7:0]  mem_q [FIFO_DEPTH];
    logic        do_push, do_pop;

    // A push into a full FIFO is dropped even if a pop happens on the same edge.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level = wr_ptr_q - rd_ptr_q;
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer registers; reset flushes the queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
        end
    end

    // Storage array; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// 8N1 UART transmitter fed from a byte FIFO; frames are sent back-to-back with no idle gap.
module uart_tx_fifo_ctrl
    import uart_tx_fifo_ctrl_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [7:0]                  in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic                        tx,
    output logic                        busy,
    output logic                        done,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int unsigned BAUD_W = cnt_width(CLKS_PER_BIT * STOP_BITS);
    localparam logic [BAUD_W-1:0] BitLast  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] StopLast = BAUD_W'(CLKS_PER_BIT * STOP_BITS - 1);
    // done is registered, so it is set one cycle early to land on the last stop cycle.
    localparam logic [BAUD_W-1:0] DoneAt   = BAUD_W'(CLKS_PER_BIT * STOP_BITS - 2);
    localparam logic [BAUD_W-1:0] BaudOne  = BAUD_W'(1);

    tx_state_e         state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic       fifo_pop, fifo_full, fifo_empty;
    logic [7:0] fifo_dout;

    uart_byte_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_valid),
        .pop   (fifo_pop),
        .din   (in_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign in_ready = !fifo_full;
    assign tx       = tx_q;
    assign busy     = busy_q;
    assign done     = done_q;

    // Next-state logic: bit timing, shifting, and popping the next byte at frame boundaries.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        done_d   = 1'b0;
        fifo_pop = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    tx_d     = 1'b0;
                    baud_d   = '0;
                    state_d  = StStart;
                end
            end
            StStart: begin
                if (baud_q == BitLast) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                    state_d = StData;
                end else begin
                    baud_d = baud_q + BaudOne;
                end
            end
            StData: begin
                if (baud_q == BitLast) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = StStop;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BaudOne;
                end
            end
            StStop: begin
                if (baud_q == DoneAt) done_d = 1'b1;
                if (baud_q == StopLast) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        // Start bit follows the stop bit directly for contiguous frames.
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dout;
                        tx_d     = 1'b0;
                        state_d  = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    baud_d = baud_q + BaudOne;
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    // State and output registers; reset aborts any frame in flight with the line idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Directed bench for uart_tx_fifo_ctrl: one instance with 1 stop bit, one with 2.
module tb_uart_tx_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data, in_data2;
    logic       in_valid, in_valid2;
    wire        in_ready, tx, busy, done;
    wire        in_ready2, tx2, busy2, done2;
    wire  [2:0] fifo_level, fifo_level2;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int d0;
    logic acc1 = 1'b0;
    logic acc2 = 1'b0;
    logic [7:0] rb;

    always #5 clk = ~clk;

    uart_tx_fifo_ctrl #(
        .CLKS_PER_BIT (16),
        .STOP_BITS    (1),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .tx         (tx),
        .busy       (busy),
        .done       (done),
        .fifo_level (fifo_level)
    );

    uart_tx_fifo_ctrl #(
        .CLKS_PER_BIT (16),
        .STOP_BITS    (2),
        .FIFO_DEPTH   (4)
    ) dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data2),
        .in_valid   (in_valid2),
        .in_ready   (in_ready2),
        .tx         (tx2),
        .busy       (busy2),
        .done       (done2),
        .fifo_level (fifo_level2)
    );

    // Acceptance seen at each edge, and a running count of done pulses.
    always @(posedge clk) begin
        acc1 <= in_valid && in_ready;
        acc2 <= in_valid2 && in_ready2;
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; accepts one byte on the next posedge, returns at the following negedge.
    task automatic push(input bit sel, input logic [7:0] b);
        if (sel) begin in_data2 = b; in_valid2 = 1'b1; end
        else     begin in_data  = b; in_valid  = 1'b1; end
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        in_valid2 = 1'b0;
        chk("push_accept", sel ? {31'd0, acc2} : {31'd0, acc1}, 32'd1);
    endtask

    // Checks {busy,done,tx} on frame cycles first..last (cycle 1 = first start-bit cycle).
    // Entered at the negedge of cycle first-1.
    task automatic check_frame(input bit sel, input logic [7:0] b, input int nstop,
                               input int first, input int last, input string tag);
        int total;
        int bad;
        int bad_c;
        logic [2:0] obs, exp, bad_obs, bad_exp;
        total = (9 + nstop) * 16;
        bad = 0;
        bad_c = 0;
        bad_obs = 3'b000;
        bad_exp = 3'b000;
        for (int c = first; c <= last; c++) begin
            @(negedge clk);
            if (c <= 16)       exp[0] = 1'b0;
            else if (c <= 144) exp[0] = b[(c - 17) / 16];
            else               exp[0] = 1'b1;
            exp[1] = (c == total);
            exp[2] = 1'b1;
            obs = sel ? {busy2, done2, tx2} : {busy, done, tx};
            if (obs !== exp) begin
                if (bad == 0) begin bad_c = c; bad_obs = obs; bad_exp = exp; end
                bad++;
            end
        end
        checks++;
        assert (bad == 0) else begin
            errors++;
            $error("FAIL %s byte=%h: %0d bad cycles, first cycle %0d {busy,done,tx}=%b expected %b",
                   tag, b, bad, bad_c, bad_obs, bad_exp);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        in_data2  = 8'h00;
        in_valid2 = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_level", {29'd0, fifo_level}, 32'd0);
        chk("rst_tx2", {31'd0, tx2}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Single byte 0xA5: one-cycle latency, exact waveform, done then busy drop
        d0 = done_cnt;
        push(1'b0, 8'hA5);
        chk("a5_latency_tx", {31'd0, tx}, 32'd1);
        chk("a5_level_queued", {29'd0, fifo_level}, 32'd1);
        check_frame(1'b0, 8'hA5, 1, 1, 160, "frame_a5");
        @(negedge clk);
        chk("a5_busy_after", {31'd0, busy}, 32'd0);
        chk("a5_done_after", {31'd0, done}, 32'd0);
        chk("a5_tx_idle", {31'd0, tx}, 32'd1);
        chk("a5_level_after", {29'd0, fifo_level}, 32'd0);
        chk("a5_done_count", done_cnt - d0, 32'd1);

        // Burst 0x01..0x05 with valid held, then 0x06 pending against a full FIFO
        d0 = done_cnt;
        for (int i = 1; i <= 5; i++) begin
            in_data  = 8'(i);
            in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk("burst_accept", {31'd0, acc1}, 32'd1);
        end
        in_data = 8'h06;
        chk("burst_full_ready", {31'd0, in_ready}, 32'd0);
        chk("burst_full_level", {29'd0, fifo_level}, 32'd4);
        check_frame(1'b0, 8'h01, 1, 5, 160, "frame_burst1");
        chk("full_ready_at_pop", {31'd0, in_ready}, 32'd0);
        check_frame(1'b0, 8'h02, 1, 1, 1, "frame_burst2");
        chk("push_refused_on_pop", {31'd0, acc1}, 32'd0);
        chk("level_after_pop", {29'd0, fifo_level}, 32'd3);
        chk("ready_after_pop", {31'd0, in_ready}, 32'd1);
        check_frame(1'b0, 8'h02, 1, 2, 2, "frame_burst2");
        chk("push_after_pop", {31'd0, acc1}, 32'd1);
        chk("level_refilled", {29'd0, fifo_level}, 32'd4);
        in_valid = 1'b0;
        check_frame(1'b0, 8'h02, 1, 3, 160, "frame_burst2");
        check_frame(1'b0, 8'h03, 1, 1, 160, "frame_burst3");
        check_frame(1'b0, 8'h04, 1, 1, 160, "frame_burst4");
        check_frame(1'b0, 8'h05, 1, 1, 160, "frame_burst5");
        check_frame(1'b0, 8'h06, 1, 1, 160, "frame_burst6");
        @(negedge clk);
        chk("burst_busy_after", {31'd0, busy}, 32'd0);
        chk("burst_done_count", done_cnt - d0, 32'd6);

        // Reset during data bit 3 of 0x3C (frame cycles 65..80)
        push(1'b0, 8'h3C);
        check_frame(1'b0, 8'h3C, 1, 1, 70, "frame_3c_pre_rst");
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("midrst_tx", {31'd0, tx}, 32'd1);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_level", {29'd0, fifo_level}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_ready", {31'd0, in_ready}, 32'd1);
        repeat (20) @(negedge clk);
        chk("midrst_no_done", done_cnt - d0, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        push(1'b0, 8'h3C);
        check_frame(1'b0, 8'h3C, 1, 1, 160, "frame_3c_after_rst");

        // All-zero and all-one bytes
        push(1'b0, 8'h00);
        check_frame(1'b0, 8'h00, 1, 1, 160, "frame_00");
        push(1'b0, 8'hFF);
        check_frame(1'b0, 8'hFF, 1, 1, 160, "frame_ff");
        @(negedge clk);

        // Two stop bits: stop held high for 32 clk, done on cycle 176
        push(1'b1, 8'h00);
        check_frame(1'b1, 8'h00, 2, 1, 176, "frame2_00");
        @(negedge clk);
        chk("stop2_busy_after", {31'd0, busy2}, 32'd0);
        push(1'b1, 8'hFF);
        check_frame(1'b1, 8'hFF, 2, 1, 176, "frame2_ff");
        @(negedge clk);

        // 32 random bytes, each frame decoded against the byte sent
        for (int i = 0; i < 32; i++) begin
            rb = 8'($urandom);
            push(1'b0, rb);
            check_frame(1'b0, rb, 1, 1, 160, "frame_rand");
        end
        @(negedge clk);
        chk("final_idle", {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
